// File: rtl/uc_pkg.sv
// Shared types and power-up contents for the microprogrammed control sequencer.
// The default store image reproduces the legacy SAP-1 instruction set.
package uc_pkg;

  localparam int FETCH_WORDS = 3;

  localparam logic [11:0] CW_IDLE = 12'h3E3;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef struct packed {
    logic        halt;
    logic        end_bit;
    logic [11:0] cw;
  } uc_word_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } uc_state_e;

  localparam logic [11:0] FETCH_CW [FETCH_WORDS] = '{12'h5E3, 12'hBE3, 12'h263};

  // Packed as {halt, end, cw}: 14'h1xxx marks end, 14'h3xxx marks halt+end.
  localparam uc_word_t UC_DEFAULT [32] = '{
    3:       uc_word_t'(14'h01A3),
    4:       uc_word_t'(14'h02C3),
    5:       uc_word_t'(14'h13E3),
    6:       uc_word_t'(14'h01A3),
    7:       uc_word_t'(14'h02E1),
    8:       uc_word_t'(14'h13C7),
    9:       uc_word_t'(14'h01A3),
    10:      uc_word_t'(14'h02E1),
    11:      uc_word_t'(14'h13CF),
    12:      uc_word_t'(14'h13F2),
    15:      uc_word_t'(14'h33E3),
    default: uc_word_t'(14'h13E3)
  };

  localparam logic [4:0] MAP_DEFAULT [16] = '{
    0:       5'd3,
    1:       5'd6,
    2:       5'd9,
    14:      5'd12,
    15:      5'd15,
    default: 5'd13
  };

  // Steps beyond the legacy fetch table drive the idle word.
  function automatic logic [11:0] fetch_cw_at(input int idx);
    if (idx >= 0 && idx < FETCH_WORDS) return FETCH_CW[idx[1:0]];
    return CW_IDLE;
  endfunction

  function automatic uc_word_t uc_default_at(input int addr);
    return UC_DEFAULT[addr[4:0]];
  endfunction

  function automatic logic [4:0] map_default_at(input int op);
    return MAP_DEFAULT[op[3:0]];
  endfunction

endpackage

// File: rtl/uc_step_ctr.sv
// Instruction step counter: holds, wraps after the last step, or reloads zero
// on an early end; also provides the one-hot step decode.
module uc_step_ctr #(
  parameter int T_STATES = 6,
  localparam int SW = $clog2(T_STATES)
) (
  input  logic                clk,
  input  logic                clear_i,
  input  logic                adv_i,
  input  logic                end_i,
  output logic [SW-1:0]       step_o,
  output logic [T_STATES-1:0] onehot_o,
  output logic                last_o
);

  logic [SW-1:0] step_q, step_d;

  assign last_o = (step_q == SW'(T_STATES - 1));

  always_comb begin
    step_d = step_q;
    if (adv_i) begin
      step_d = (end_i || last_o) ? '0 : step_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear_i) step_q <= '0;
    else         step_q <= step_d;
  end

  assign step_o   = step_q;
  assign onehot_o = T_STATES'(1) << step_q;

endmodule

// File: rtl/uc_sequencer.sv
// Microprogrammed control sequencer: fixed fetch steps followed by per-opcode
// micro-words read from a writable microcode store via an opcode map.
module uc_sequencer
  import uc_pkg::*;
#(
  parameter int              OP_W      = 4,
  parameter int              CW_W      = 12,
  parameter int              T_STATES  = 6,
  parameter int              FETCH_LEN = 3,
  parameter int              UADDR_W   = 5,
  parameter logic [CW_W-1:0] CW_IDLE   = CW_W'(uc_pkg::CW_IDLE)
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                run,
  input  logic [OP_W-1:0]     instruction,
  input  logic                uc_we,
  input  logic [UADDR_W-1:0]  uc_waddr,
  input  logic [CW_W+1:0]     uc_wdata,
  input  logic                map_we,
  input  logic [OP_W-1:0]     map_op,
  input  logic [UADDR_W-1:0]  map_wdata,
  output logic [CW_W-1:0]     cu_out,
  output logic [T_STATES-1:0] t_state,
  output logic                instr_done,
  output logic                halted
);

  localparam int UC_DEPTH  = 1 << UADDR_W;
  localparam int MAP_DEPTH = 1 << OP_W;
  localparam int UC_W      = CW_W + 2;
  localparam int SW        = $clog2(T_STATES);

  logic [UC_W-1:0]    uc_rd  [UC_DEPTH];
  logic [UADDR_W-1:0] map_rd [MAP_DEPTH];

  // Stores keep their contents across clear; only power-up loads the defaults.
  for (genvar gi = 0; gi < UC_DEPTH; gi++) begin : g_uc
    localparam uc_word_t INIT = uc_default_at(gi);
    logic [UC_W-1:0] word_q = {INIT.halt, INIT.end_bit, CW_W'(INIT.cw)};
    always_ff @(posedge clk) begin
      if (uc_we && uc_waddr == UADDR_W'(gi)) word_q <= uc_wdata;
    end
    assign uc_rd[gi] = word_q;
  end

  for (genvar gi = 0; gi < MAP_DEPTH; gi++) begin : g_map
    logic [UADDR_W-1:0] base_q = UADDR_W'(map_default_at(gi));
    always_ff @(posedge clk) begin
      if (map_we && map_op == OP_W'(gi)) base_q <= map_wdata;
    end
    assign map_rd[gi] = base_q;
  end

  logic [SW-1:0]      step;
  logic               last_step;
  logic               adv;
  logic               is_fetch;
  logic               word_end;
  logic               word_halt;
  logic [UADDR_W-1:0] uaddr;
  logic [UC_W-1:0]    word;
  uc_state_e          state_q, state_d;

  uc_step_ctr #(
    .T_STATES (T_STATES)
  ) u_step_ctr (
    .clk      (clk),
    .clear_i  (clear),
    .adv_i    (adv),
    .end_i    (word_end),
    .step_o   (step),
    .onehot_o (t_state),
    .last_o   (last_step)
  );

  // Offset wraps modulo the store depth; its value is ignored during fetch.
  assign is_fetch  = int'(step) < FETCH_LEN;
  assign uaddr     = map_rd[instruction] + UADDR_W'(int'(step) - FETCH_LEN);
  assign word      = uc_rd[uaddr];
  assign word_end  = !is_fetch && word[CW_W];
  assign word_halt = !is_fetch && word[CW_W+1];

  always_comb begin
    state_d    = state_q;
    cu_out     = CW_IDLE;
    instr_done = 1'b0;
    adv        = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (run) begin
          adv        = 1'b1;
          instr_done = word_end || last_step;
          if (word_halt) begin
            state_d = ST_HALTED;
          end else if (is_fetch) begin
            cu_out = CW_W'(fetch_cw_at(int'(step)));
          end else begin
            cu_out = word[CW_W-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  assign halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_uc_sequencer.sv
// Randomised self-checking bench for uc_sequencer against an instruction-level
// model of the fetch/microcode sequence.
module tb_uc_sequencer;

  localparam int T_ST = 6;
  localparam int F_LEN = 3;

  logic        clk = 1'b0;
  logic        clear, run;
  logic [3:0]  instruction;
  logic        uc_we;
  logic [4:0]  uc_waddr;
  logic [13:0] uc_wdata;
  logic        map_we;
  logic [3:0]  map_op;
  logic [4:0]  map_wdata;
  logic [11:0] cu_out;
  logic [5:0]  t_state;
  logic        instr_done, halted;

  int n_cmp = 0;
  int n_err = 0;

  logic [13:0] m_uc  [32];
  logic [4:0]  m_map [16];
  logic [11:0] exp_cw [$];
  bit          exp_done [$];

  always #5 clk = ~clk;

  uc_sequencer dut (
    .clk         (clk),
    .clear       (clear),
    .run         (run),
    .instruction (instruction),
    .uc_we       (uc_we),
    .uc_waddr    (uc_waddr),
    .uc_wdata    (uc_wdata),
    .map_we      (map_we),
    .map_op      (map_op),
    .map_wdata   (map_wdata),
    .cu_out      (cu_out),
    .t_state     (t_state),
    .instr_done  (instr_done),
    .halted      (halted)
  );

  task automatic model_init();
    for (int a = 0; a < 32; a++) m_uc[a] = 14'h13E3;
    m_uc[3] = 14'h01A3;  m_uc[4] = 14'h02C3;  m_uc[5] = 14'h13E3;
    m_uc[6] = 14'h01A3;  m_uc[7] = 14'h02E1;  m_uc[8] = 14'h13C7;
    m_uc[9] = 14'h01A3;  m_uc[10] = 14'h02E1; m_uc[11] = 14'h13CF;
    m_uc[12] = 14'h13F2; m_uc[15] = 14'h33E3;
    for (int o = 0; o < 16; o++) m_map[o] = 5'd13;
    m_map[0] = 5'd3; m_map[1] = 5'd6; m_map[2] = 5'd9;
    m_map[14] = 5'd12; m_map[15] = 5'd15;
  endtask

  // Whole-instruction view: three fetch words, then micro-words from the
  // mapped base until an end bit or the step limit.
  task automatic model_instr(input logic [3:0] op);
    logic [11:0] fetch [3];
    logic [13:0] w;
    int a;
    fetch[0] = 12'h5E3; fetch[1] = 12'hBE3; fetch[2] = 12'h263;
    exp_cw.delete();
    exp_done.delete();
    for (int s = 0; s < T_ST; s++) begin
      if (s < F_LEN) begin
        exp_cw.push_back(fetch[s]);
        exp_done.push_back(s == T_ST - 1);
      end else begin
        a = (int'(m_map[op]) + s - F_LEN) % 32;
        w = m_uc[a[4:0]];
        exp_cw.push_back(w[13] ? 12'h3E3 : w[11:0]);
        exp_done.push_back(w[12] || s == T_ST - 1);
        if (w[12]) break;
      end
    end
  endtask

  task automatic uc_write(input logic [4:0] a, input logic [13:0] d);
    run = 1'b0; uc_we = 1'b1; uc_waddr = a; uc_wdata = d;
    @(posedge clk); #1;
    uc_we = 1'b0;
    m_uc[a] = d;
  endtask

  task automatic map_write(input logic [3:0] op, input logic [4:0] base);
    run = 1'b0; map_we = 1'b1; map_op = op; map_wdata = base;
    @(posedge clk); #1;
    map_we = 1'b0;
    m_map[op] = base;
  endtask

  // Runs one instruction starting at step 0; optional stalls and an optional
  // store write on the edge that ends step wr_at.
  task automatic run_instr(input logic [3:0] op, input string name,
                           input int stall_at, input int stall_pct,
                           input int wr_at, input logic [4:0] wa, input logic [13:0] wd);
    logic [5:0] exp_ts;
    int ns;
    model_instr(op);
    for (int i = 0; i < exp_cw.size(); i++) begin
      exp_ts = 6'(1) << i;
      ns = 0;
      if (i == stall_at) ns = 3;
      else if (stall_pct > 0 && $urandom_range(99) < stall_pct) ns = $urandom_range(1, 2);
      for (int k = 0; k < ns; k++) begin
        run = 1'b0; instruction = op;
        @(negedge clk);
        n_cmp++;
        if (cu_out !== 12'h3E3 || t_state !== exp_ts || instr_done !== 1'b0) begin
          n_err++;
          $display("FAIL %s stall step %0d: cu_out=%h t_state=%b done=%b, need cu_out=3e3 t_state=%b done=0",
                   name, i, cu_out, t_state, instr_done, exp_ts);
        end
        @(posedge clk); #1;
      end
      run = 1'b1; instruction = op;
      if (i == wr_at) begin
        uc_we = 1'b1; uc_waddr = wa; uc_wdata = wd;
      end
      @(negedge clk);
      n_cmp++;
      if (cu_out !== exp_cw[i]) begin
        n_err++;
        $display("FAIL %s cu_out step %0d: got %h need %h", name, i, cu_out, exp_cw[i]);
      end
      n_cmp++;
      if (instr_done !== exp_done[i]) begin
        n_err++;
        $display("FAIL %s instr_done step %0d: got %b need %b", name, i, instr_done, exp_done[i]);
      end
      n_cmp++;
      if (t_state !== exp_ts || halted !== 1'b0) begin
        n_err++;
        $display("FAIL %s t_state/halted step %0d: got %b/%b need %b/0", name, i, t_state, halted, exp_ts);
      end
      @(posedge clk); #1;
      uc_we = 1'b0;
    end
    if (wr_at >= 0) m_uc[wa] = wd;
    $display("instr %s op=%h len=%0d", name, op, exp_cw.size());
  endtask

  task automatic test_reset();
    clear = 1'b1; run = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (t_state !== 6'b000001 || cu_out !== 12'h5E3 || halted !== 1'b0 || instr_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: t_state=%b cu_out=%h halted=%b done=%b, need 000001/5e3/0/0",
               t_state, cu_out, halted, instr_done);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (t_state !== 6'b000001 || cu_out !== 12'h5E3) begin
      n_err++;
      $display("FAIL mid_clear: t_state=%b cu_out=%h, need 000001/5e3", t_state, cu_out);
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    $display("reset done");
  endtask

  task automatic test_legacy();
    run_instr(uc_pkg::OP_LDA, "LDA", -1, 0, -1, 5'd0, 14'h0);
    run_instr(uc_pkg::OP_ADD, "ADD", -1, 0, -1, 5'd0, 14'h0);
    run_instr(uc_pkg::OP_SUB, "SUB", -1, 0, -1, 5'd0, 14'h0);
    run_instr(uc_pkg::OP_OUT, "OUT", -1, 0, -1, 5'd0, 14'h0);
  endtask

  task automatic test_early_end();
    run_instr(uc_pkg::OP_OUT, "OUT_early", -1, 0, -1, 5'd0, 14'h0);
    run_instr(4'h7, "NOP7", -1, 0, -1, 5'd0, 14'h0);
    run_instr(uc_pkg::OP_LDA, "LDA_after_nop", -1, 0, -1, 5'd0, 14'h0);
  endtask

  task automatic test_run_stall();
    run_instr(uc_pkg::OP_ADD, "ADD_stall", 4, 0, -1, 5'd0, 14'h0);
  endtask

  task automatic test_reprogram();
    uc_write(5'd20, 14'h0111);
    uc_write(5'd21, 14'h1222);
    map_write(4'h3, 5'd20);
    run_instr(4'h3, "OP3_new", -1, 0, -1, 5'd0, 14'h0);
    // Overwrite uc[21] on the edge ending the step that reads it.
    run_instr(4'h3, "OP3_rdwr", -1, 0, 4, 5'd21, 14'h1333);
    run_instr(4'h3, "OP3_after", -1, 0, -1, 5'd0, 14'h0);
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(4) == 0) begin
        uc_write(5'($urandom_range(16, 31)),
                 {1'b0, 1'($urandom_range(1)), 12'($urandom_range(4095))});
        map_write(4'($urandom_range(14)), 5'($urandom_range(16, 31)));
      end
      op = 4'($urandom_range(14));
      run_instr(op, "rand", -1, 25, -1, 5'd0, 14'h0);
    end
  endtask

  task automatic test_halt();
    logic [5:0] frozen;
    run_instr(uc_pkg::OP_HLT, "HLT", -1, 0, -1, 5'd0, 14'h0);
    frozen = t_state;
    for (int c = 0; c < 12; c++) begin
      run = 1'b1;
      instruction = 4'($urandom_range(15));
      @(negedge clk);
      n_cmp++;
      if (halted !== 1'b1 || cu_out !== 12'h3E3 || instr_done !== 1'b0 || t_state !== frozen) begin
        n_err++;
        $display("FAIL halted cycle %0d: halted=%b cu_out=%h done=%b t_state=%b, need 1/3e3/0/%b",
                 c, halted, cu_out, instr_done, t_state, frozen);
      end
      @(posedge clk); #1;
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    run_instr(uc_pkg::OP_LDA, "LDA_after_clear", -1, 0, -1, 5'd0, 14'h0);
    run_instr(uc_pkg::OP_OUT, "OUT_after_clear", -1, 0, -1, 5'd0, 14'h0);
  endtask

  initial begin
    clear = 1'b1; run = 1'b0; instruction = 4'h0;
    uc_we = 1'b0; uc_waddr = 5'd0; uc_wdata = 14'h0;
    map_we = 1'b0; map_op = 4'h0; map_wdata = 5'd0;
    model_init();
    test_reset();
    test_legacy();
    test_early_end();
    test_run_stall();
    test_reprogram();
    test_random();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uc_sequencer.md
# uc_sequencer

Parametrised microprogrammed control sequencer for the 8-bit SAP-style computer; successor to the fixed six-T-state control unit. It steps through a fixed fetch sequence, then executes opcode-specific micro-steps from a writable microcode store. Each instruction may end early through a per-word end bit, and an HLT micro-word freezes the machine. It drives the datapath control word from the top level, and the instruction register feeds its `instruction` input.

## Interface
- `OP_W`, 4: opcode width.
- `CW_W`, 12: control-word width.
- `T_STATES`, 6: maximum steps per instruction, fetch steps included; must be ≥ `FETCH_LEN`+1.
- `FETCH_LEN`, 3: number of fixed fetch steps.
- `UADDR_W`, 5: microcode address width, giving a depth of 2^`UADDR_W`.
- `CW_IDLE`, 12'h3E3: control word with every load and enable inactive.

- `clk` in 1: clock; all state updates on the rising edge.
- `clear` in 1: reset; one clock; reset is synchronous and active-high.
- `run` in 1: advance enable.
- `instruction` in `OP_W`: opcode from the IR; stable during execute steps.
- `uc_we` in 1: microcode write strobe.
- `uc_waddr` in `UADDR_W`: microcode write address.
- `uc_wdata` in `CW_W`+2: write data, laid out as {halt, end, cw}.
- `map_we` in 1: opcode-map write strobe.
- `map_op` in `OP_W`: opcode-map write index.
- `map_wdata` in `UADDR_W`: base address written to the opcode map.
- `cu_out` out `CW_W`: control word.
- `t_state` out `T_STATES`: one-hot current step.
- `instr_done` out 1: high during the last step of an instruction.
- `halted` out 1: high once HLT has executed.

## Operation
- **State:** a step counter `step` (0..`T_STATES`-1) and a `halted` flag.
  - On `clear`: `step`=0, `halted`=0.
  - Reset values of the outputs: `t_state`=1, `instr_done`=0, `halted`=0, `cu_out`=`FETCH_CW[0]`.
- **Fetch steps** (`step` < `FETCH_LEN`): `cu_out` = `FETCH_CW[step]`, taken from a package constant.
- **Execute steps:**
  - Micro-address = `map[instruction]` + (`step` − `FETCH_LEN`), modulo 2^`UADDR_W`.
  - `cu_out` = `cw` field of that word.
- **End of instruction:** when the word's end bit is set, or `step` = `T_STATES`-1:
  - `instr_done` = 1;
  - the next step is 0.
- **Halt bit:**
  - While the current word has its halt bit set, `cu_out` = `CW_IDLE`.
  - On the next edge with `run`=1, `halted` is set.
- **While halted:**
  - `step` holds, `cu_out` = `CW_IDLE`, `instr_done` = 0.
  - Only `clear` exits this state.
- **`run`=0:** `step` holds, `cu_out` = `CW_IDLE`, `instr_done` = 0. Advance resumes at the same step.
- **Store writes:** `uc_we` and `map_we` write on the edge, independent of `run` and `halted`.
  - A read of the same address in the same cycle returns the old contents.
  - The new contents are visible from the next cycle.
- **Store reset:** the stores are not cleared by `clear`. They initialise from the package defaults, which give legacy SAP-1 behaviour.
  - Fetch words: 5E3, BE3, 263.
  - LDA (0): base 3, words 1A3, 2C3, 3E3(end).
  - ADD (1): base 6, words 1A3, 2E1, 3C7(end).
  - SUB (2): base 9, words 1A3, 2E1, 3CF(end).
  - OUT (E): base 12, word 3F2(end).
  - HLT (F): base 15, word 3E3(halt, end).
  - Every other opcode: base 13, NOP word 3E3(end).

## Timing
- `step` advances one position per `clk` with `run`=1.
- `cu_out`, `t_state` and `instr_done` are combinational from registered state and the stores; they are valid in the same cycle as the state.
- Instruction latency:
  - full length: `T_STATES` cycles;
  - with an end bit at execute step k (0-based): `FETCH_LEN`+k+1 cycles.
- The last step of an instruction is followed directly by fetch step 0; there is no bubble.
- `clear` takes priority over `run`, halt, and the store write strobes' effect on `step`; the stores still accept writes during `clear`.
- `clear` asserted mid-instruction forces `step`=0 on the next edge.

## Structure
- **Package `uc_pkg`:**
  - `FETCH_CW` array;
  - default microcode and map arrays;
  - `uc_word_t` struct {halt, end, cw};
  - `CW_IDLE`;
  - legacy opcode constants.
- **Sub-module `uc_step_ctr`:** step counter with hold, wrap and early-end load-to-zero, plus a one-hot decode of the step.
- **Top level:** instantiates the two storage arrays and the output mux.

## Test plan
- **Reset:** `clear` for 1 cycle → `t_state`=6'b000001, `cu_out`=5E3, `halted`=0.
- **Legacy programme:** run LDA, ADD, SUB, OUT with defaults → `cu_out` sequences, in order:
  - LDA: 5E3, BE3, 263, 1A3, 2C3, 3E3
  - ADD: 5E3, BE3, 263, 1A3, 2E1, 3C7
  - SUB: 5E3, BE3, 263, 1A3, 2E1, 3CF
  - OUT: 5E3, BE3, 263, 3F2

  `instr_done` is high on the last word of each instruction.
- **Early end:** OUT takes 4 cycles; fetch step 0 follows immediately. Opcode 7 (NOP) takes 4 cycles, with `cu_out`=3E3 on its execute step.
- **HLT:** opcode F executes → `halted`=1 after the HLT step, `cu_out`=3E3 thereafter, `t_state` frozen for ≥10 cycles; `clear` → fetch restarts.
- **`run` stall:** deassert `run` at ADD step 4 for 3 cycles → `cu_out`=3E3 and `t_state` held; on resume the next word is 2E1.
- **Reprogramming:**
  - Write map[3]=20 and uc[20]={0,0,0x111}, uc[21]={0,1,0x222}; issue opcode 3 → execute words 111, 222, `instr_done` on 222.
  - Write uc[21] in the same cycle it is read → the old value is output.
